// File: rtl/klp32_pkg.sv
// Shared KLP32 core constants: register width and data-memory geometry.
package klp32_pkg;

  localparam int XLEN        = 32;
  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DEPTH  = 1024;

endpackage : klp32_pkg

// File: rtl/memory_word.sv
// One storage word of the data memory: enabled load, asynchronous active-low clear.
module memory_word
  import klp32_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (we) begin
      data_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign rdata = data_q;

endmodule : memory_word

// File: rtl/memory.sv
// KLP32 data memory: single address port, synchronous full-word writes,
// combinational reads, every word cleared by the asynchronous reset.
module memory
  import klp32_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              in_range;
  logic [DEPTH-1:0]  word_we;
  logic [DATA_W-1:0] word_rd [DEPTH];

  assign in_range = ({1'b0, addr} < DEPTH_L);

  always_comb begin
    word_we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (write_enable && in_range && (addr == ADDR_W'(i))) begin
        word_we[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    memory_word #(
      .DATA_W(DATA_W)
    ) u_word (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (word_we[g]),
      .wdata(write_data),
      .rdata(word_rd[g])
    );
  end

  // Unimplemented addresses fall through to zero.
  always_comb begin
    read_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (in_range && (addr == ADDR_W'(i))) begin
        read_data = word_rd[i];
      end
    end
  end

endmodule : memory

// File: tb/tb_memory.sv
// Scoreboard bench for the KLP32 data memory against an array reference model.
module tb_memory;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk;
  logic              rst_n;
  logic              write_enable;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  typedef struct {
    logic [DATA_W-1:0] exp;
    int                a;
  } exp_t;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] model [DEPTH];
  int                vectors;
  int                miscompares;
  event              smp;

  memory #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_enable(write_enable),
    .addr        (addr),
    .write_data  (write_data),
    .read_data   (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] model_read(int a);
    if (a >= DEPTH) return '0;
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic push_expect(int a);
    exp_t e;
    e.exp = model_read(a);
    e.a   = a;
    sb_q.push_back(e);
    ->smp;
  endtask

  // Read-only look at one address, no clock edge involved.
  task automatic probe(int a);
    write_enable = 1'b0;
    addr         = ADDR_W'(a);
    #1;
    push_expect(a);
    #2;
  endtask

  // One clock cycle: inputs driven at negedge, old contents expected before
  // the edge, model updated on the edge exactly like a word-wide store.
  task automatic cycle(logic we, int a, logic [DATA_W-1:0] d);
    @(negedge clk);
    write_enable = we;
    addr         = ADDR_W'(a);
    write_data   = d;
    #1;
    push_expect(a);
    @(posedge clk);
    if (we && rst_n && a < DEPTH) model[a] = d;
    #1;
  endtask

  // Monitor: every sample request pops one expectation and compares.
  initial begin
    forever begin
      @(smp);
      #1;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow addr=%0d got=%h required=<none>", addr, read_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        vectors++;
        if (read_data !== e.exp) begin
          miscompares++;
          $display("FAIL read addr=%0d got=%h required=%h", e.a, read_data, e.exp);
        end
      end
    end
  end

  initial begin
    int a;
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    write_enable = 1'b0;
    addr         = '0;
    write_data   = '0;
    model_clear();

    // Reset state
    #2;
    probe(3);
    #10;
    rst_n = 1'b1;
    probe(3);

    // Directed plan
    cycle(1'b1, 1, 32'hDEADBEEF);
    cycle(1'b0, 1, 32'h0);
    cycle(1'b1, 2, 32'h12345678);
    cycle(1'b0, 2, 32'h0);
    cycle(1'b0, 1, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1, 32'hFFFFFFFF);
    cycle(1'b1, 1023, 32'hA5A5A5A5);
    cycle(1'b1, 0, 32'h5A5A5A5A);
    probe(1023);
    probe(0);
    probe(1);
    probe(2);

    // Same-address read-during-write: old value before, new after
    cycle(1'b1, 2, 32'hCAFEF00D);
    probe(2);

    // Asynchronous reset off the clock grid, write attempted during it
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_clear();
    probe(1);
    probe(2);
    probe(1023);
    write_enable = 1'b1;
    addr         = ADDR_W'(1);
    write_data   = 32'h77777777;
    @(posedge clk);
    #1;
    probe(1);
    #3;
    rst_n = 1'b1;
    probe(1);
    probe(0);

    // Randomized traffic, addresses clustered to force reuse
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 15);
        1: a = $urandom_range(DEPTH - 8, DEPTH - 1);
        default: a = $urandom_range(0, DEPTH - 1);
      endcase
      cycle(1'($urandom_range(0, 1)), a, $urandom);
      if (n % 16 == 0) probe($urandom_range(0, 15));
    end

    #5;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_memory
